ic1406_monitor: RTL

Downstream checker for the ic1406 two-flip-flop circuit. Samples its Q1/Q0/Z outputs every enabled clock and detects a programmable four-symbol state sequence. It flags stuck state and Z-parity violations, and publishes per-window statistics (Z-high count, match count) through a valid/ack report port. It sits directly after ic1406 in the lab datapath and feeds the board-level result logic.

---
 rtl/ic1406_pkg.sv | 20 ++
 rtl/ic1406_seq_detect.sv | 43 ++++
 rtl/ic1406_monitor.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/ic1406_pkg.sv
// Shared types, constants and helpers for the ic1406 output monitor.
package ic1406_pkg;

    typedef logic [1:0] sym_t;

    localparam logic [7:0] DEFAULT_PATTERN = 8'b00_01_11_10;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } rpt_state_t;

    localparam int SAT_W = 16;

    function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] value,
                                                 input logic [SAT_W-1:0] limit);
        return (value >= limit) ? value : value + SAT_W'(1);
    endfunction

endpackage

// File: rtl/ic1406_seq_detect.sv
// Four-symbol sequence detector: shifts in {Q1,Q0} symbols and flags a
// completed PATTERN once four symbols have been seen since reset.
module ic1406_seq_detect
    import ic1406_pkg::*;
#(
    parameter logic [7:0] PATTERN = DEFAULT_PATTERN
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  sym_t sym,
    output logic match,
    output logic match_now
);

    logic [7:0] hist;
    logic [7:0] hist_next;
    logic [2:0] fill;
    logic [2:0] fill_next;

    // Next history/fill and the same-cycle match used by the window accumulators.
    always_comb begin
        hist_next = {hist[5:0], sym};
        fill_next = 3'(sat_inc(SAT_W'(fill), SAT_W'(4)));
        match_now = en && (fill_next == 3'd4) && (hist_next == PATTERN);
    end

    // History register and registered match pulse; history freezes while en is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist  <= '0;
            fill  <= '0;
            match <= 1'b0;
        end else begin
            match <= match_now;
            if (en) begin
                hist <= hist_next;
                fill <= fill_next;
            end
        end
    end

endmodule

// File: rtl/ic1406_monitor.sv
// Downstream checker for ic1406: sequence match, stuck-state and Z-parity
// detection, and per-window Z/match statistics through a valid/ack port.
module ic1406_monitor
    import ic1406_pkg::*;
#(
    parameter int         WINDOW      = 16,
    parameter int         CNT_W       = 5,
    parameter logic [7:0] PATTERN     = DEFAULT_PATTERN,
    parameter int         STUCK_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             Q0,
    input  logic             Q1,
    input  logic             Z,
    output logic             match,
    output logic             stuck,
    output logic             err,
    output logic             report_valid,
    input  logic             report_ack,
    output logic [CNT_W-1:0] report_z,
    output logic [CNT_W-1:0] report_m,
    output logic             overrun
);

    localparam int RUN_W = $clog2(STUCK_LIMIT + 1);
    localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [SAT_W-1:0] CNT_MAX = SAT_W'((1 << CNT_W) - 1);

    sym_t             sym;
    sym_t             prev_sym;
    logic [RUN_W-1:0] run;
    logic [RUN_W-1:0] run_next;
    logic [WIN_W-1:0] win_cnt;
    logic [CNT_W-1:0] z_acc;
    logic [CNT_W-1:0] m_acc;
    logic [CNT_W-1:0] z_next;
    logic [CNT_W-1:0] m_next;
    logic             match_now;
    logic             win_close;
    logic             load_report;
    logic             set_overrun;
    rpt_state_t       state;
    rpt_state_t       state_next;

    assign sym = {Q1, Q0};

    ic1406_seq_detect #(
        .PATTERN(PATTERN)
    ) u_seq_detect (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .sym      (sym),
        .match    (match),
        .match_now(match_now)
    );

    // Run length of identical samples; a zero run means no sample since reset.
    always_comb begin
        run_next = RUN_W'(1);
        if ((run != '0) && (sym == prev_sym)) begin
            run_next = RUN_W'(sat_inc(SAT_W'(run), SAT_W'(STUCK_LIMIT)));
        end
    end

    // Window totals including the current sample, and the window-close strobe.
    always_comb begin
        z_next    = Z ? CNT_W'(sat_inc(SAT_W'(z_acc), CNT_MAX)) : z_acc;
        m_next    = match_now ? CNT_W'(sat_inc(SAT_W'(m_acc), CNT_MAX)) : m_acc;
        win_close = en && (win_cnt == WIN_W'(WINDOW - 1));
    end

    // Report slot control: a closing window either fills the slot or is dropped.
    always_comb begin
        state_next  = state;
        load_report = 1'b0;
        set_overrun = 1'b0;
        case (state)
            IDLE: begin
                if (win_close) begin
                    state_next  = HOLD;
                    load_report = 1'b1;
                end
            end
            HOLD: begin
                if (win_close) begin
                    if (report_ack) begin
                        load_report = 1'b1;
                    end else begin
                        set_overrun = 1'b1;
                    end
                end else if (report_ack) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Report FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    assign report_valid = (state == HOLD);

    // Sample-driven state: run/stuck, sticky err, window accumulators and report data.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_sym <= '0;
            run      <= '0;
            stuck    <= 1'b0;
            err      <= 1'b0;
            win_cnt  <= '0;
            z_acc    <= '0;
            m_acc    <= '0;
            report_z <= '0;
            report_m <= '0;
            overrun  <= 1'b0;
        end else begin
            if (en) begin
                prev_sym <= sym;
                run      <= run_next;
                stuck    <= (run_next == RUN_W'(STUCK_LIMIT));
                if (Z != (Q0 ^ Q1)) begin
                    err <= 1'b1;
                end
                if (win_close) begin
                    win_cnt <= '0;
                    z_acc   <= '0;
                    m_acc   <= '0;
                end else begin
                    win_cnt <= win_cnt + WIN_W'(1);
                    z_acc   <= z_next;
                    m_acc   <= m_next;
                end
            end
            if (load_report) begin
                report_z <= z_next;
                report_m <= m_next;
            end
            if (set_overrun) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule
